// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: steps each instruction through
// fetch/decode/execute/memory/write-back and drives every datapath mux/enable.
// Control outputs are decoded combinationally from the current state. In FETCH
// they also depend on mem_ready. While rst is high they are all held at 0.
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             illegal_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_retired
);

    localparam logic [5:0] OPC_R    = 6'h00;
    localparam logic [5:0] OPC_LW   = 6'h23;
    localparam logic [5:0] OPC_SW   = 6'h2B;
    localparam logic [5:0] OPC_BEQ  = 6'h04;
    localparam logic [5:0] OPC_J    = 6'h02;
    localparam logic [5:0] OPC_ADDI = 6'h08;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_WB_R     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_EXEC_I   = 4'd10,
        S_WB_I     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   retire;

    // The zero flag is ANDed with pc_write_cond in the datapath, not here.
    logic unused_zero;
    assign unused_zero = zero;

    assign state = state_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Sticky illegal-opcode flag, set on entry to TRAP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_op <= 1'b0;
        end else if (state_d == S_TRAP) begin
            illegal_op <= 1'b1;
        end
    end

    // Retired-instruction counter, wraps modulo 2^CNT_W
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_retired <= '0;
        end else if (retire) begin
            instr_retired <= instr_retired + CNT_W'(1);
        end
    end

    // Next-state and control decode; everything is held at 0 during reset
    always_comb begin
        state_d       = state_q;
        retire        = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    if (mem_ready) begin
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Branch target PC+4+(imm<<2) is parked in ALUOut here
                    alu_src_b = 2'b11;
                    case (opcode)
                        OPC_LW, OPC_SW: state_d = S_MEM_ADDR;
                        OPC_R:          state_d = S_EXEC_R;
                        OPC_BEQ:        state_d = S_BRANCH;
                        OPC_J:          state_d = S_JUMP;
                        OPC_ADDI:       state_d = S_EXEC_I;
                        default:        state_d = S_TRAP;
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (opcode == OPC_LW) ? S_MEM_RD : S_MEM_WR;
                end
                S_MEM_RD: begin
                    iord     = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        state_d = S_MEM_WB;
                    end
                end
                S_MEM_WB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    state_d    = S_FETCH;
                    retire     = 1'b1;
                end
                S_MEM_WR: begin
                    iord      = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    state_d   = S_WB_R;
                end
                S_WB_R: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                    retire    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    state_d       = S_FETCH;
                    retire        = 1'b1;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                    state_d   = S_FETCH;
                    retire    = 1'b1;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = S_WB_I;
                end
                S_WB_I: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                    retire    = 1'b1;
                end
                S_TRAP: begin
                    state_d = S_TRAP;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. The reference model describes each
// opcode as a list of visited states, lists which states wait on memory, and
// gives the control word expected in each state. A second instance built with
// CNT_W=4 checks that the retired counter wraps.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;

    logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [31:0] instr_retired;

    logic        d4_pc_write, d4_pc_write_cond, d4_iord, d4_mem_read, d4_mem_write, d4_ir_write;
    logic        d4_mem_to_reg, d4_reg_dst, d4_reg_write, d4_alu_src_a, d4_illegal_op;
    logic [1:0]  d4_alu_src_b, d4_alu_op, d4_pc_source;
    logic [3:0]  d4_state;
    logic [3:0]  d4_instr_retired;

    int          checks = 0;
    int          errors = 0;
    int unsigned exp_cnt = 0;

    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_J = 6'h02, OP_ADDI = 6'h08;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .illegal_op(illegal_op), .state(state),
        .instr_retired(instr_retired)
    );

    multicycle_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(d4_pc_write), .pc_write_cond(d4_pc_write_cond), .iord(d4_iord),
        .mem_read(d4_mem_read), .mem_write(d4_mem_write), .ir_write(d4_ir_write),
        .mem_to_reg(d4_mem_to_reg), .reg_dst(d4_reg_dst), .reg_write(d4_reg_write),
        .alu_src_a(d4_alu_src_a), .alu_src_b(d4_alu_src_b), .alu_op(d4_alu_op),
        .pc_source(d4_pc_source), .illegal_op(d4_illegal_op), .state(d4_state),
        .instr_retired(d4_instr_retired)
    );

    // Observed control word: pc_write, pc_write_cond, iord, mem_read, mem_write,
    // ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
    logic [15:0] ctrl;
    assign ctrl = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

    // Expected control word for a state, taken from the per-state output table
    function automatic logic [15:0] exp_ctrl(input int st, input logic mr);
        logic pcw, pcc, io, mrd, mwr, irw, m2r, rd, rw, asa;
        logic [1:0] asb, aop, psrc;
        {pcw, pcc, io, mrd, mwr, irw, m2r, rd, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            0:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
            1:  asb = 2'b11;
            2:  begin asa = 1'b1; asb = 2'b10; end
            3:  begin io = 1'b1; mrd = 1'b1; end
            4:  begin m2r = 1'b1; rw = 1'b1; end
            5:  begin io = 1'b1; mwr = 1'b1; end
            6:  begin asa = 1'b1; aop = 2'b10; end
            7:  begin rd = 1'b1; rw = 1'b1; end
            8:  begin asa = 1'b1; aop = 2'b01; pcc = 1'b1; psrc = 2'b01; end
            9:  begin pcw = 1'b1; psrc = 2'b10; end
            10: begin asa = 1'b1; asb = 2'b10; end
            11: rw = 1'b1;
            default: ;
        endcase
        return {pcw, pcc, io, mrd, mwr, irw, m2r, rd, rw, asa, asb, aop, psrc};
    endfunction

    // Ideal-memory latency of each legal opcode
    function automatic int base_latency(input logic [5:0] opc);
        case (opc)
            OP_BEQ, OP_J:        return 3;
            OP_R, OP_ADDI, OP_SW: return 4;
            OP_LW:               return 5;
            default:             return 0;
        endcase
    endfunction

    function automatic logic [5:0] rand_legal_op();
        logic [5:0] ops [6];
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
        return ops[$urandom_range(0, 5)];
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    // Drive one whole instruction and check every cycle against the model
    task automatic run_instr(input logic [5:0] opc, input int fw, input int mw,
                             output int cycles, output int rw_cnt);
        int path[$];
        int waits;
        logic [15:0] ec;
        case (opc)
            OP_R:    path = '{0, 1, 6, 7};
            OP_LW:   path = '{0, 1, 2, 3, 4};
            OP_SW:   path = '{0, 1, 2, 5};
            OP_BEQ:  path = '{0, 1, 8};
            OP_J:    path = '{0, 1, 9};
            default: path = '{0, 1, 10, 11};
        endcase
        cycles = 0;
        rw_cnt = 0;
        foreach (path[i]) begin
            waits = (path[i] == 0) ? fw : ((path[i] == 3 || path[i] == 5) ? mw : 0);
            for (int w = 0; w <= waits; w++) begin
                @(negedge clk);
                opcode = opc;
                zero = 1'($urandom);
                if (path[i] == 0 || path[i] == 3 || path[i] == 5)
                    mem_ready = (w == waits);
                else
                    mem_ready = 1'($urandom);
                #1;
                cycles++;
                ec = exp_ctrl(path[i], mem_ready);
                checks++;
                if (state !== 4'(path[i])) begin
                    errors++;
                    $display("FAIL state op=%h step=%0d: got %0d expected %0d", opc, i, state, path[i]);
                end
                checks++;
                if (ctrl !== ec) begin
                    errors++;
                    $display("FAIL ctrl op=%h state=%0d: got %h expected %h", opc, path[i], ctrl, ec);
                end
                checks++;
                if (illegal_op !== 1'b0) begin
                    errors++;
                    $display("FAIL illegal_op op=%h: got %b expected 0", opc, illegal_op);
                end
                checks++;
                if (instr_retired !== exp_cnt || d4_instr_retired !== 4'(exp_cnt)) begin
                    errors++;
                    $display("FAIL retired op=%h: got %0d/%0d expected %0d/%0d", opc,
                             instr_retired, d4_instr_retired, exp_cnt, exp_cnt % 16);
                end
                if (reg_write) rw_cnt++;
                if (i == path.size() - 1 && w == waits) exp_cnt++;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'($urandom);
        #1;
        checks++;
        if (ctrl !== 16'h0 || state !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ctrl=%h state=%0d expected 0/0", ctrl, state);
        end
        checks++;
        if (illegal_op !== 1'b0 || instr_retired !== 32'd0 || d4_instr_retired !== 4'd0) begin
            errors++;
            $display("FAIL reset_regs: got illegal=%b cnt=%0d cnt4=%0d expected 0", illegal_op,
                     instr_retired, d4_instr_retired);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_rtype();
        int cyc, rw;
        run_instr(OP_R, 0, 0, cyc, rw);
        checks++;
        if (cyc != 4 || rw != 1) begin
            errors++;
            $display("FAIL rtype_latency: got cycles=%0d reg_writes=%0d expected 4/1", cyc, rw);
        end
    endtask

    task automatic test_lw_wait();
        int cyc, rw;
        run_instr(OP_LW, 0, 2, cyc, rw);
        checks++;
        if (cyc != 7 || rw != 1) begin
            errors++;
            $display("FAIL lw_wait: got cycles=%0d reg_writes=%0d expected 7/1", cyc, rw);
        end
    endtask

    task automatic test_back_to_back();
        int cyc, rw;
        run_instr(OP_BEQ, 0, 0, cyc, rw);
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL beq_latency: got %0d expected 3", cyc);
        end
        run_instr(OP_J, 0, 0, cyc, rw);
        checks++;
        if (cyc != 3) begin
            errors++;
            $display("FAIL j_latency: got %0d expected 3", cyc);
        end
    endtask

    task automatic test_random();
        int cyc, rw, fw, mw, lat;
        logic [5:0] op;
        for (int n = 0; n < 40; n++) begin
            op = rand_legal_op();
            fw = $urandom_range(0, 2);
            mw = $urandom_range(0, 2);
            run_instr(op, fw, mw, cyc, rw);
            lat = base_latency(op) + fw + ((op == OP_LW || op == OP_SW) ? mw : 0);
            checks++;
            if (cyc != lat) begin
                errors++;
                $display("FAIL rand_latency op=%h: got %0d expected %0d", op, cyc, lat);
            end
        end
    endtask

    task automatic test_trap();
        int cyc, rw;
        apply_reset();
        run_instr(OP_ADDI, 0, 0, cyc, rw);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            opcode = 6'h3F;
            mem_ready = (c == 0) ? 1'b1 : 1'($urandom);
            #1;
            checks++;
            if (state !== ((c == 0) ? 4'd0 : (c == 1) ? 4'd1 : 4'd12)) begin
                errors++;
                $display("FAIL trap_state c=%0d: got %0d", c, state);
            end
            if (c >= 2) begin
                checks++;
                if (illegal_op !== 1'b1 || ctrl !== 16'h0 || instr_retired !== exp_cnt) begin
                    errors++;
                    $display("FAIL trap_hold c=%0d: got illegal=%b ctrl=%h cnt=%0d expected 1/0/%0d",
                             c, illegal_op, ctrl, instr_retired, exp_cnt);
                end
            end
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (illegal_op !== 1'b0 || state !== 4'd0) begin
            errors++;
            $display("FAIL trap_clear: got illegal=%b state=%0d expected 0/0", illegal_op, state);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_reset_mid_wr();
        int cyc, rw;
        int st [5];
        logic mr [5];
        st = '{0, 1, 2, 5, 5};
        mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        apply_reset();
        run_instr(OP_R, 0, 0, cyc, rw);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            opcode = OP_SW;
            mem_ready = mr[c];
            #1;
            checks++;
            if (state !== 4'(st[c])) begin
                errors++;
                $display("FAIL mid_wr_state c=%0d: got %0d expected %0d", c, state, st[c]);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (ctrl !== 16'h0 || mem_write !== 1'b0 || state !== 4'd0) begin
            errors++;
            $display("FAIL mid_wr_reset: got ctrl=%h mem_write=%b state=%0d expected 0", ctrl,
                     mem_write, state);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        run_instr(OP_R, 0, 0, cyc, rw);
    endtask

    task automatic test_wrap();
        int cyc, rw;
        apply_reset();
        for (int n = 0; n < 15; n++)
            run_instr(rand_legal_op(), $urandom_range(0, 1), $urandom_range(0, 1), cyc, rw);
        checks++;
        if (exp_cnt != 15) begin
            errors++;
            $display("FAIL wrap_setup: got %0d expected 15", exp_cnt);
        end
        run_instr(OP_SW, 0, 1, cyc, rw);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (d4_instr_retired !== 4'd0 || instr_retired !== 32'd16) begin
            errors++;
            $display("FAIL wrap: got cnt4=%0d cnt=%0d expected 0/16", d4_instr_retired, instr_retired);
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        test_reset();
        test_rtype();
        test_lw_wait();
        test_back_to_back();
        test_random();
        test_trap();
        test_reset_mid_wr();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
